// File: rtl/segdisplay.sv
// segdisplay: memory-mapped N-digit seven-segment display controller.
// Registers: 0 VALUE, 1 CTRL, 2 STATUS (read-only), 3 reserved.
// Drives static per-digit segments plus a time-multiplexed scan port.
// Optional blink feature is built when SEGDISPLAY_BLINK_EN is defined.
module segdisplay #(
    parameter int DIGITS     = 4,
    parameter int SCAN_BITS  = 16,
    parameter int BLINK_BITS = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [1:0]          addr,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata,
    output logic [7*DIGITS-1:0] seg,
    output logic [DIGITS-1:0]   dp,
    output logic [6:0]          scan_seg,
    output logic                scan_dp,
    output logic [DIGITS-1:0]   scan_an
);
    localparam logic [1:0] ADDR_VALUE  = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [2:0] LAST_DIGIT  = 3'(DIGITS - 1);

    // Hex nibble to active-low {g,f,e,d,c,b,a} glyph.
    function automatic logic [6:0] glyph(input logic [3:0] nib);
        case (nib)
            4'h0:    glyph = 7'b1000000;
            4'h1:    glyph = 7'b1111001;
            4'h2:    glyph = 7'b0100100;
            4'h3:    glyph = 7'b0110000;
            4'h4:    glyph = 7'b0011001;
            4'h5:    glyph = 7'b0010010;
            4'h6:    glyph = 7'b0000010;
            4'h7:    glyph = 7'b1111000;
            4'h8:    glyph = 7'b0000000;
            4'h9:    glyph = 7'b0010000;
            4'hA:    glyph = 7'b0001000;
            4'hB:    glyph = 7'b0000011;
            4'hC:    glyph = 7'b1000110;
            4'hD:    glyph = 7'b0100001;
            4'hE:    glyph = 7'b0000110;
            4'hF:    glyph = 7'b0001110;
            default: glyph = 7'b1111111;
        endcase
    endfunction

    logic [4*DIGITS-1:0] r_value;
    logic                r_en;
    logic                r_lzb;
    logic [DIGITS-1:0]   r_dpmask;
    logic [SCAN_BITS-1:0] r_presc;
    logic [2:0]          r_scan_idx;
    logic [15:0]         r_frame;

    logic                w_presc_tc;
    logic                w_frame_wrap;
    logic                w_phase;
    logic [DIGITS-1:0]   w_blink_hide;
    logic [DIGITS-1:0]   w_blank;
    logic [7*DIGITS-1:0] w_seg;
    logic [DIGITS-1:0]   w_dp;
    logic [6:0]          w_scan_seg;
    logic                w_scan_dp;
    logic [DIGITS-1:0]   w_scan_an;
    logic [31:0]         w_rdata;
    logic                w_unused_wdata;

    // Not every write-data bit maps to a field for every DIGITS setting.
    assign w_unused_wdata = ^wdata;

    assign w_presc_tc   = (r_presc == {SCAN_BITS{1'b1}});
    assign w_frame_wrap = w_presc_tc & (r_scan_idx == LAST_DIGIT);

`ifdef SEGDISPLAY_BLINK_EN
    logic [DIGITS-1:0]     r_blinkmask;
    logic [BLINK_BITS-1:0] r_blink_cnt;
    logic                  r_blink_phase;

    assign w_phase      = r_blink_phase;
    assign w_blink_hide = r_blinkmask & {DIGITS{r_blink_phase}};

    // Blink counter advances once per frame; phase flips when it wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_frame_wrap) begin
            r_blink_cnt <= r_blink_cnt + BLINK_BITS'(1);
            if (r_blink_cnt == {BLINK_BITS{1'b1}}) begin
                r_blink_phase <= ~r_blink_phase;
            end
        end
    end
`else
    localparam int UNUSED_BLINK_BITS = BLINK_BITS;

    assign w_phase      = 1'b0;
    assign w_blink_hide = '0;
`endif

    // CPU-writable register file; STATUS and reserved writes are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_value  <= '0;
            r_en     <= 1'b0;
            r_lzb    <= 1'b0;
            r_dpmask <= '0;
`ifdef SEGDISPLAY_BLINK_EN
            r_blinkmask <= '0;
`endif
        end else if (we) begin
            case (addr)
                ADDR_VALUE: r_value <= wdata[4*DIGITS-1:0];
                ADDR_CTRL: begin
                    r_en     <= wdata[0];
                    r_lzb    <= wdata[1];
                    r_dpmask <= wdata[8 +: DIGITS];
`ifdef SEGDISPLAY_BLINK_EN
                    r_blinkmask <= wdata[16 +: DIGITS];
`endif
                end
                default: ;
            endcase
        end
    end

    // Free-running prescaler, scan digit and frame counter; writes never touch them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc    <= '0;
            r_scan_idx <= 3'd0;
            r_frame    <= 16'd0;
        end else begin
            r_presc <= r_presc + SCAN_BITS'(1);
            if (w_presc_tc) begin
                if (r_scan_idx == LAST_DIGIT) begin
                    r_scan_idx <= 3'd0;
                    r_frame    <= r_frame + 16'd1;
                end else begin
                    r_scan_idx <= r_scan_idx + 3'd1;
                end
            end
        end
    end

    // Per-digit blanking (enable, leading zeros, blink) and glyph selection.
    always_comb begin : static_digits
        logic w_zero_run;
        w_zero_run = 1'b1;
        w_blank    = '0;
        w_seg      = '1;
        w_dp       = '1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_zero_run = w_zero_run & (r_value[4*i +: 4] == 4'd0);
            w_blank[i] = ~r_en | (r_lzb & w_zero_run & (i != 0)) | w_blink_hide[i];
            if (w_blank[i]) begin
                w_seg[7*i +: 7] = 7'b1111111;
                w_dp[i]         = 1'b1;
            end else begin
                w_seg[7*i +: 7] = glyph(r_value[4*i +: 4]);
                w_dp[i]         = ~r_dpmask[i];
            end
        end
    end

    // Route the current scan digit's static value onto the shared lines.
    always_comb begin
        w_scan_seg = 7'b1111111;
        w_scan_dp  = 1'b1;
        w_scan_an  = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_scan_idx == 3'(i)) begin
                w_scan_seg   = w_seg[7*i +: 7];
                w_scan_dp    = w_dp[i];
                w_scan_an[i] = 1'b0;
            end else begin
                w_scan_an[i] = 1'b1;
            end
        end
    end

    // Read mux over the current (pre-write) register contents.
    always_comb begin
        w_rdata = 32'd0;
        case (addr)
            ADDR_VALUE: w_rdata[4*DIGITS-1:0] = r_value;
            ADDR_CTRL: begin
                w_rdata[0]           = r_en;
                w_rdata[1]           = r_lzb;
                w_rdata[8 +: DIGITS] = r_dpmask;
`ifdef SEGDISPLAY_BLINK_EN
                w_rdata[16 +: DIGITS] = r_blinkmask;
`endif
            end
            ADDR_STATUS: begin
                w_rdata[2:0]   = r_scan_idx;
                w_rdata[3]     = w_phase;
                w_rdata[31:16] = r_frame;
            end
            default: w_rdata = 32'd0;
        endcase
    end

    // Output registers; reset blanks everything and selects digit 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata    <= 32'd0;
            seg      <= '1;
            dp       <= '1;
            scan_seg <= 7'b1111111;
            scan_dp  <= 1'b1;
            scan_an  <= ~DIGITS'(1'b1);
        end else begin
            rdata    <= w_rdata;
            seg      <= w_seg;
            dp       <= w_dp;
            scan_seg <= w_scan_seg;
            scan_dp  <= w_scan_dp;
            scan_an  <= w_scan_an;
        end
    end

endmodule

// File: tb/tb_segdisplay.sv
// Self-checking bench for segdisplay: directed cases plus randomized bus
// traffic checked every cycle against a tick-count based reference model.
module tb_segdisplay;
    localparam int DIG = 4;
    localparam int SB  = 2;
    localparam int BB  = 1;
`ifdef SEGDISPLAY_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif
    localparam logic [31:0] VMASK = 32'((64'd1 << (4*DIG)) - 64'd1);
    localparam logic [7:0]  DMASK = 8'((16'd1 << DIG) - 16'd1);
    localparam logic [6:0]  GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    logic               clk = 1'b0;
    logic               reset;
    logic               we;
    logic [1:0]         addr;
    logic [31:0]        wdata;
    logic [31:0]        rdata;
    logic [7*DIG-1:0]   seg;
    logic [DIG-1:0]     dp;
    logic [6:0]         scan_seg;
    logic               scan_dp;
    logic [DIG-1:0]     scan_an;

    segdisplay #(.DIGITS(DIG), .SCAN_BITS(SB), .BLINK_BITS(BB)) dut (
        .clk(clk), .reset(reset), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .seg(seg), .dp(dp), .scan_seg(scan_seg),
        .scan_dp(scan_dp), .scan_an(scan_an));

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state: clock ticks since reset plus register contents.
    int          m_ticks;
    logic [31:0] m_value;
    bit          m_en;
    bit          m_lzb;
    logic [7:0]  m_dpm;
    logic [7:0]  m_bm;

    logic [7*DIG-1:0] e_seg;
    logic [DIG-1:0]   e_dp;
    logic [6:0]       e_sseg;
    logic             e_sdp;
    logic [DIG-1:0]   e_san;
    logic [31:0]      e_rdata;

    function automatic int f_idx(int t);
        return (t >> SB) % DIG;
    endfunction

    function automatic int f_frames(int t);
        return (t >> SB) / DIG;
    endfunction

    function automatic bit f_phase(int t);
        if (!BLINK) return 1'b0;
        return ((f_frames(t) >> BB) % 2) == 1;
    endfunction

    function automatic bit f_blank(int i);
        bit b;
        b = !m_en;
        if (m_lzb && i != 0 && (m_value >> (4*i)) == 32'd0) b = 1'b1;
        if (BLINK && m_bm[i] && f_phase(m_ticks)) b = 1'b1;
        return b;
    endfunction

    function automatic logic [6:0] f_dseg(int i);
        logic [3:0] nib;
        nib = m_value[4*i +: 4];
        if (f_blank(i)) return 7'h7F;
        return GLYPH[nib];
    endfunction

    function automatic logic f_ddp(int i);
        if (f_blank(i)) return 1'b1;
        return ~m_dpm[i];
    endfunction

    function automatic logic [7*DIG-1:0] f_seg();
        logic [7*DIG-1:0] s;
        for (int i = 0; i < DIG; i++) s[7*i +: 7] = f_dseg(i);
        return s;
    endfunction

    function automatic logic [DIG-1:0] f_dp();
        logic [DIG-1:0] d;
        for (int i = 0; i < DIG; i++) d[i] = f_ddp(i);
        return d;
    endfunction

    function automatic logic [31:0] f_rdata(logic [1:0] a);
        case (a)
            2'd0:    return m_value;
            2'd1:    return {8'h00, (BLINK ? m_bm : 8'h00), m_dpm, 6'd0, m_lzb, m_en};
            2'd2:    return {16'(f_frames(m_ticks)), 12'd0, f_phase(m_ticks), 3'(f_idx(m_ticks))};
            default: return 32'd0;
        endcase
    endfunction

    // Reference model: outputs after an edge come from the state before it.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ticks <= 0;
            m_value <= 32'd0;
            m_en    <= 1'b0;
            m_lzb   <= 1'b0;
            m_dpm   <= 8'd0;
            m_bm    <= 8'd0;
            e_seg   <= '1;
            e_dp    <= '1;
            e_sseg  <= 7'h7F;
            e_sdp   <= 1'b1;
            e_san   <= ~DIG'(1'b1);
            e_rdata <= 32'd0;
        end else begin
            e_seg   <= f_seg();
            e_dp    <= f_dp();
            e_sseg  <= f_dseg(f_idx(m_ticks));
            e_sdp   <= f_ddp(f_idx(m_ticks));
            e_san   <= ~(DIG'(1'b1) << f_idx(m_ticks));
            e_rdata <= f_rdata(addr);
            if (we && addr == 2'd0) m_value <= wdata & VMASK;
            if (we && addr == 2'd1) begin
                m_en  <= wdata[0];
                m_lzb <= wdata[1];
                m_dpm <= wdata[15:8] & DMASK;
                m_bm  <= BLINK ? (wdata[23:16] & DMASK) : 8'd0;
            end
            m_ticks <= m_ticks + 1;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("seg",      32'(seg),      32'(e_seg));
            chk("dp",       32'(dp),       32'(e_dp));
            chk("scan_seg", 32'(scan_seg), 32'(e_sseg));
            chk("scan_dp",  32'(scan_dp),  32'(e_sdp));
            chk("scan_an",  32'(scan_an),  32'(e_san));
            chk("rdata",    rdata,         e_rdata);
        end
    end

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    logic [15:0] f0;
    logic [15:0] f1;
    bit          found;

    initial begin
        reset = 1'b1; we = 1'b0; addr = 2'd0; wdata = 32'd0;
        @(posedge clk);
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_seg", 32'(seg), 32'h0FFF_FFFF);
        chk("rst_scan_an", 32'(scan_an), 32'h0000_000E);
        chk("rst_rdata", rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Hex glyphs on all four digits.
        wr(2'd1, 32'h0000_0001);
        wr(2'd0, 32'h0000_A3B6);
        @(posedge clk); #1;
        chk("hex_seg", 32'(seg), 32'({7'b0001000, 7'b0110000, 7'b0000011, 7'b0000010}));

        // Leading-zero blanking with decimal points.
        wr(2'd0, 32'h0000_0070);
        wr(2'd1, 32'h0000_0503);
        @(posedge clk); #1;
        chk("lzb_seg", 32'(seg), 32'({7'b1111111, 7'b1111111, 7'b1111000, 7'b1000000}));
        chk("lzb_dp", 32'(dp), 32'h0000_000E);

        // Frame counter advances once per DIG * 2^SB clocks.
        @(negedge clk); addr = 2'd2;
        @(posedge clk); #1; f0 = rdata[31:16];
        repeat (16) @(posedge clk);
        #1; f1 = rdata[31:16];
        chk("frame_step", 32'(f1 - f0), 32'd1);

        // Blink mask readback and blinking digit 0.
        wr(2'd1, 32'h00FF_0001);
        addr = 2'd1;
        @(posedge clk); #1;
        chk("ctrl_rb", rdata, BLINK ? 32'h000F_0001 : 32'h0000_0001);
        wr(2'd0, 32'h0000_1235);
        wr(2'd1, 32'h0001_0001);
        repeat (80) @(posedge clk);

        // Randomized bus traffic.
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            we    = ($urandom % 4) == 0;
            addr  = 2'($urandom % 4);
            wdata = $urandom;
            if (addr == 2'd0) wdata = wdata & (32'hFFFF >> (4 * ($urandom % 5)));
            if (addr == 2'd1 && ($urandom % 4) != 0) wdata[0] = 1'b1;
        end
        @(negedge clk); we = 1'b0;

        // Asynchronous reset while scanning digit 2.
        wr(2'd0, 32'h0000_8888);
        wr(2'd1, 32'h0000_0F01);
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (f_idx(m_ticks) == 2) found = 1'b1;
        end
        chk("wait_idx2", 32'(found), 32'd1);
        #2; reset = 1'b1; #1;
        chk("mid_rst_seg", 32'(seg), 32'h0FFF_FFFF);
        chk("mid_rst_dp", 32'(dp), 32'h0000_000F);
        chk("mid_rst_scan_an", 32'(scan_an), 32'h0000_000E);
        chk("mid_rst_scan_seg", 32'(scan_seg), 32'h0000_007F);
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b0; addr = 2'd0;
        @(posedge clk); #1;
        chk("post_rst_value", rdata, 32'd0);
        @(negedge clk); addr = 2'd1;
        @(posedge clk); #1;
        chk("post_rst_ctrl", rdata, 32'd0);
        repeat (20) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
